sar_adc_mc: RTL and testbench
=============================

# sar_adc_mc

Multi-channel successive-approximation ADC controller, successor to the single-channel SAR_ADC. It sequences an external analog mux over up to CH_NUM inputs and waits a programmable settling time per channel. It drives the DAC trial word MSB-first from an external comparator and emits one tagged result per enabled channel. It supports single-scan or continuous operation and optional oversampling/averaging, and sits between the analog front end (mux, DAC, comparator) and the digital data consumer.

## Interface
- ADC_WIDTH, 8: result and DAC word width, ≥2.
- CH_NUM, 4: number of mux channels, 1..16; CW = max(1, $clog2(CH_NUM)).
- SETTLE_CYC, 2: mux settling cycles before each channel's first conversion, ≥1.
- AVG_LOG2, 2: log2 of conversions averaged per channel (used only with SAR_AVG_EN), 0..4.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmp  in  1  comparator: 1 = Vin ≥ DACF, sampled at end of each trial cycle.
- start  in  1  scan request, sampled each cycle.
- ch_mask  in  CH_NUM  enabled channels, captured when start is accepted.
- cont  in  1  continuous mode, sampled at end of each scan.
- busy  out  1  high from the cycle after start is accepted until the scan completes.
- ch_sel  out  CW  analog mux select.
- DACF  out  ADC_WIDTH  DAC trial word.
- den  out  1  one-cycle result strobe.
- dch  out  CW  channel of the current result.
- Dout  out  ADC_WIDTH  result; held between strobes.
- eoc  out  1  one-cycle end-of-scan strobe, coincident with the last den of the scan.

## Operation
- States: IDLE, SETTLE, CONV, RESULT.
- IDLE → SETTLE when start=1 and ch_mask≠0.
  - Capture the mask.
  - ch_sel = lowest set bit.
- start is ignored while busy, and ignored when ch_mask=0 (busy stays 0).
- SETTLE: SETTLE_CYC cycles with DACF=0, then → CONV.
- CONV: ADC_WIDTH trial cycles, bit i = ADC_WIDTH-1 down to 0.
  - DACF = kept bits | (1<<i).
  - Bit i is kept iff cmp=1 at the closing edge.
- Averaging (SAR_AVG_EN only): 2^AVG_LOG2 conversions run back-to-back with no re-settle.
  - Sum into an accumulator of width ADC_WIDTH+AVG_LOG2.
  - Dout = sum >> AVG_LOG2, truncated.
- RESULT: one cycle with den=1, dch=ch_sel, Dout=result, DACF=0.
- After RESULT:
  - If a higher masked channel remains → SETTLE on the next set bit, ascending order.
  - Else this is the last channel: eoc=1 in the same RESULT cycle.
    - If cont=1 → SETTLE on the lowest masked channel, using the same captured mask; busy stays 1.
    - Else → IDLE.
- Deasserting cont takes effect at the end of the current scan; a scan is never truncated.
- Reset values (also applied immediately on rst mid-operation): state IDLE; busy, ch_sel, DACF, den, dch, Dout, eoc all 0; accumulator and captured mask 0.

## Timing
- start sampled at edge k → busy=1 and SETTLE from cycle k+1.
- Per-channel latency is N = 1 without SAR_AVG_EN, N = 2^AVG_LOG2 with it:
  - SETTLE_CYC cycles in SETTLE.
  - ADC_WIDTH·N cycles in CONV.
  - 1 cycle in RESULT (den).
- Defaults, no averaging: first den 11 cycles after the start edge, i.e. in cycle k+11.
- busy falls in the cycle after the final RESULT when returning to IDLE.
- A start arriving in that same cycle is accepted.
- den and eoc are single-cycle and never stretched.
- dch and Dout change only in RESULT cycles.

## Configuration
- SAR_AVG_EN defined: averaging engine and accumulator are compiled in; AVG_LOG2 is honoured.
- SAR_AVG_EN undefined: exactly one conversion per channel; AVG_LOG2 is ignored; no accumulator logic.

## Structure
- Package sar_pkg holds:
  - the state enum (IDLE, SETTLE, CONV, RESULT);
  - a function computing CW from CH_NUM;
  - a next-set-bit priority function over the mask.
- Sub-module sar_core: a single-conversion engine (bit counter, trial/keep register, DACF generation, done pulse).
  - Instantiated once.
  - sar_adc_mc holds the sequencer, settle counter, averaging accumulator and output registers.

## Test plan
Behavioural comparator: cmp = (vin[ch_sel] ≥ DACF). Defaults unless stated.
- mask=0001, vin0=0xA5, one start pulse → one den in cycle k+11 with Dout=0xA5, dch=0, eoc=1 in the same cycle; busy low afterwards.
- mask=1010, vin1=0x00, vin3=0xFF → den with dch=1/Dout=0x00, then den with dch=3/Dout=0xFF 11 cycles later; eoc only on the second.
- cont=1, mask=0001, vin0=0x3C → den every 11 cycles with Dout=0x3C. Dropping cont mid-scan → exactly one further den+eoc, then busy=0.
- Extra start pulses while busy → no change in the result sequence. start with mask=0 → busy stays 0, no den.
- rst pulsed in the 4th CONV cycle → all outputs 0 immediately. The next start yields a correct result (vin0=0x5A → Dout=0x5A).
- SAR_AVG_EN, AVG_LOG2=2, vin0 stepping 0x10, 0x11, 0x12, 0x13 per conversion → single den at cycle k+35 with Dout=0x11.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared types and helpers for the multi-channel SAR ADC controller:
// sequencer states, mux-select width and next-enabled-channel search.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CONV,
    RESULT
  } state_e;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } nb_t;

  // Mux select width: max(1, clog2(n)).
  function automatic int cw_of(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Lowest set bit of m at index >= from.
  function automatic nb_t next_bit(
    input logic [15:0] m,
    input logic [4:0]  from
  );
    nb_t r;
    r = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i] && (5'(i) >= from)) begin
        r.found = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sar_core.sv
// Single SAR conversion engine: walks the trial bit MSB-first while run
// is high, keeps bits on cmp, and pulses done with the result.
module sar_core
  import sar_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         cmp,
  output logic [W-1:0] dacf,
  output logic         done,
  output logic [W-1:0] res
);

  localparam int BW = $clog2(W);

  logic [BW-1:0] bit_q, bit_d;
  logic [W-1:0]  keep_q, keep_d;
  logic [W-1:0]  trial;

  // Trial word, keep decision and bit walk; rearms after the LSB.
  always_comb begin
    trial  = keep_q | (W'(1) << bit_q);
    res    = cmp ? trial : keep_q;
    dacf   = run ? trial : '0;
    done   = run && (bit_q == '0);
    bit_d  = BW'(W - 1);
    keep_d = '0;
    if (run && !done) begin
      bit_d  = bit_q - BW'(1);
      keep_d = res;
    end
  end

  // Engine state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q  <= BW'(W - 1);
      keep_q <= '0;
    end else begin
      bit_q  <= bit_d;
      keep_q <= keep_d;
    end
  end

endmodule

// File: rtl/sar_adc_mc.sv
// Multi-channel SAR ADC sequencer: mux settle, per-channel conversion,
// tagged results; define SAR_AVG_EN to average 2^AVG_LOG2 conversions.
module sar_adc_mc
  import sar_pkg::*;
#(
  parameter int ADC_WIDTH  = 8,
  parameter int CH_NUM     = 4,
  parameter int SETTLE_CYC = 2,
  parameter int AVG_LOG2   = 2,
  localparam int CW = cw_of(CH_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmp,
  input  logic                 start,
  input  logic [CH_NUM-1:0]    ch_mask,
  input  logic                 cont,
  output logic                 busy,
  output logic [CW-1:0]        ch_sel,
  output logic [ADC_WIDTH-1:0] DACF,
  output logic                 den,
  output logic [CW-1:0]        dch,
  output logic [ADC_WIDTH-1:0] Dout,
  output logic                 eoc
);

  localparam int SW = $clog2(SETTLE_CYC + 1);

  if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg
    $error("AVG_LOG2 out of range");
  end

  state_e                state_q, state_d;
  logic [CH_NUM-1:0]     mask_q, mask_d;
  logic [CW-1:0]         ch_q, ch_d;
  logic [CW-1:0]         dch_q, dch_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic [ADC_WIDTH-1:0]  dout_q, dout_d;
  logic                  done;
  logic [ADC_WIDTH-1:0]  res;
  nb_t                   first, nxt, init;

`ifdef SAR_AVG_EN
  localparam int AW = ADC_WIDTH + AVG_LOG2;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [4:0]    cnt_q, cnt_d;
`endif

  sar_core #(
    .W(ADC_WIDTH)
  ) u_core (
    .clk (clk),
    .rst (rst),
    .run (state_q == CONV),
    .cmp (cmp),
    .dacf(DACF),
    .done(done),
    .res (res)
  );

  // Scan sequencer: next state, channel walk and result capture.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ch_d     = ch_q;
    settle_d = settle_q;
    dout_d   = dout_q;
    dch_d    = dch_q;
    first    = next_bit(16'(mask_q), 5'd0);
    nxt      = next_bit(16'(mask_q), 5'(ch_q) + 5'd1);
    init     = next_bit(16'(ch_mask), 5'd0);
`ifdef SAR_AVG_EN
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sum      = acc_q + AW'(res);
`endif
    unique case (state_q)
      IDLE: begin
        if (start && init.found) begin
          state_d  = SETTLE;
          mask_d   = ch_mask;
          ch_d     = CW'(init.idx);
          settle_d = '0;
        end
      end
      SETTLE: begin
        if (settle_q == SW'(SETTLE_CYC - 1)) begin
          state_d = CONV;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      CONV: begin
        if (done) begin
`ifdef SAR_AVG_EN
          if (cnt_q == 5'((1 << AVG_LOG2) - 1)) begin
            state_d = RESULT;
            dout_d  = sum[AW-1:AVG_LOG2];
            dch_d   = ch_q;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 5'd1;
          end
`else
          state_d = RESULT;
          dout_d  = res;
          dch_d   = ch_q;
`endif
        end
      end
      RESULT: begin
        settle_d = '0;
        state_d  = SETTLE;
        if (nxt.found) begin
          ch_d = CW'(nxt.idx);
        end else if (cont && first.found) begin
          ch_d = CW'(first.idx);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      ch_q     <= '0;
      settle_q <= '0;
      dout_q   <= '0;
      dch_q    <= '0;
`ifdef SAR_AVG_EN
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      ch_q     <= ch_d;
      settle_q <= settle_d;
      dout_q   <= dout_d;
      dch_q    <= dch_d;
`ifdef SAR_AVG_EN
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign busy   = (state_q != IDLE);
  assign den    = (state_q == RESULT);
  assign eoc    = den && !nxt.found;
  assign ch_sel = ch_q;
  assign dch    = dch_q;
  assign Dout   = dout_q;

endmodule

// File: tb/tb_sar_adc_mc.sv
// Scoreboard bench for sar_adc_mc: directed scans against a behavioural
// comparator; a negedge monitor checks every den against the queue.
module tb_sar_adc_mc;

  localparam int W  = 8;
  localparam int ST = 2;
`ifdef SAR_AVG_EN
  localparam int N = 4;
`else
  localparam int N = 1;
`endif
  localparam int LAT = ST + W * N + 1;

  logic       clk = 1'b0;
  logic       rst, cmp, start, cont;
  logic       busy, den, eoc;
  logic [3:0] ch_mask;
  logic [1:0] ch_sel, dch;
  logic [7:0] dacf, dout;
  logic [7:0] vin [4];

  int cyc   = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int ch;
    int d;
    int e;
    int at;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign cmp = (vin[ch_sel] >= dacf);

  sar_adc_mc dut (
    .clk    (clk),
    .rst    (rst),
    .cmp    (cmp),
    .start  (start),
    .ch_mask(ch_mask),
    .cont   (cont),
    .busy   (busy),
    .ch_sel (ch_sel),
    .DACF   (dacf),
    .den    (den),
    .dch    (dch),
    .Dout   (dout),
    .eoc    (eoc)
  );

  // Monitor: every strobe must match the head of the queue.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (den === 1'b1) begin
        exp_t e;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL den_unexpected: dch=%0d Dout=%0h cyc=%0d, want none",
                   dch, dout, cyc);
        end else begin
          e = q.pop_front();
          if (dch !== e.ch[1:0] || dout !== e.d[7:0] ||
              eoc !== e.e[0] || cyc != e.at) begin
            fails++;
            $display("FAIL result: dch=%0d Dout=%0h eoc=%0b cyc=%0d, want %0d %0h %0b %0d",
                     dch, dout, eoc, cyc, e.ch, e.d, e.e, e.at);
          end
        end
      end else if (eoc !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL eoc_alone: eoc=%0b cyc=%0d, want 0", eoc, cyc);
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", n, act, want);
    end
  endtask

  task automatic push(input int ch, input int d, input int e, input int at);
    exp_t x;
    x.ch = ch;
    x.d  = d;
    x.e  = e;
    x.at = at;
    q.push_back(x);
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic kick(input logic [3:0] m, output int c);
    c       = cyc;
    ch_mask = m;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results missing, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ch_sel"}, 32'(ch_sel), 0);
    chk({tag, "_dacf"}, 32'(dacf), 0);
    chk({tag, "_den"}, 32'(den), 0);
    chk({tag, "_dch"}, 32'(dch), 0);
    chk({tag, "_dout"}, 32'(dout), 0);
    chk({tag, "_eoc"}, 32'(eoc), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: sim still running, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    rst     = 1'b1;
    start   = 1'b0;
    cont    = 1'b0;
    ch_mask = '0;
    for (int i = 0; i < 4; i++) vin[i] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    // single channel
    vin[0] = 8'hA5;
    kick(4'b0001, c);
    push(0, 'hA5, 1, c + LAT);
    chk("busy_rise", 32'(busy), 1);
    wait_cyc(c + LAT + 1);
    chk("busy_fall", 32'(busy), 0);
    drain(5);

    // two channels, ascending
    vin[1] = 8'h00;
    vin[3] = 8'hFF;
    kick(4'b1010, c);
    push(1, 'h00, 0, c + LAT);
    push(3, 'hFF, 1, c + 2 * LAT);
    chk("ch_first", 32'(ch_sel), 1);
    wait_cyc(c + LAT + 1);
    chk("ch_second", 32'(ch_sel), 3);
    wait_cyc(c + 2 * LAT + 1);
    chk("busy_fall2", 32'(busy), 0);
    drain(5);

    // continuous, cont dropped mid-scan
    vin[0] = 8'h3C;
    cont   = 1'b1;
    kick(4'b0001, c);
    for (int i = 1; i <= 4; i++) push(0, 'h3C, 1, c + i * LAT);
    wait_cyc(c + 3 * LAT + 5);
    cont = 1'b0;
    chk("busy_cont", 32'(busy), 1);
    wait_cyc(c + 4 * LAT + 1);
    chk("busy_cont_end", 32'(busy), 0);
    drain(5);
    repeat (LAT + 2) @(negedge clk);

    // extra starts while busy are ignored
    vin[0] = 8'h77;
    kick(4'b0001, c);
    push(0, 'h77, 1, c + LAT);
    wait_cyc(c + 3);
    ch_mask = 4'b1111;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_cyc(c + 7);
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_cyc(c + LAT + 1);
    chk("busy_extra", 32'(busy), 0);
    drain(5);
    repeat (LAT + 2) @(negedge clk);

    // start with empty mask
    kick(4'b0000, c);
    chk("busy_mask0", 32'(busy), 0);
    wait_cyc(c + LAT + 2);
    chk("busy_mask0_late", 32'(busy), 0);
    chk("dout_held", 32'(dout), 'h77);

    // reset in the 4th trial cycle, then recover
    vin[2] = 8'hFF;
    kick(4'b0100, c);
    wait_cyc(c + 6);
    chk("dacf_4th", 32'(dacf), 'hF0);
    chk("ch_sel_2", 32'(ch_sel), 2);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vin[0] = 8'h5A;
    kick(4'b0001, c);
    push(0, 'h5A, 1, c + LAT);
    wait_cyc(c + LAT + 1);
    chk("busy_after_rst", 32'(busy), 0);
    drain(5);

`ifdef SAR_AVG_EN
    // averaging of a stepping input
    vin[0] = 8'h10;
    kick(4'b0001, c);
    push(0, 'h11, 1, c + LAT);
    for (int j = 1; j <= 3; j++) begin
      wait_cyc(c + 3 + 8 * j);
      vin[0] = 8'(8'h10 + j);
    end
    wait_cyc(c + LAT + 1);
    drain(5);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
